// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Assembles 5-byte command frames (SYNC, ADDR, DHI, DLO, CHK) from the uart_receive
//   byte stream. It presents each frame whose checksum matches as one register-write
//   command through a valid/ready handshake. It also flags bad checksums, mid-frame
//   timeouts and overruns.
// Ports
//   CLK          system clock
//   RST          synchronous active-high reset
//   DATA         received byte, qualified by RXD_READY
//   RXD_READY    one-cycle strobe per received byte
//   CMD_VALID    command pending; held until CMD_READY
//   CMD_READY    consumer accept
//   CMD_ADDR     register address
//   CMD_DATA     register data {DHI, DLO}
//   ERR_CHK      1-cycle pulse: checksum mismatch, frame dropped
//   ERR_TIMEOUT  1-cycle pulse: inter-byte gap inside a frame too long
//   ERR_OVERRUN  1-cycle pulse: byte arrived while a command was pending, byte dropped
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 50000,
    parameter int unsigned TO_W      = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  DATA,
    input  logic        RXD_READY,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    output logic [7:0]  CMD_ADDR,
    output logic [15:0] CMD_DATA,
    output logic        ERR_CHK,
    output logic        ERR_TIMEOUT,
    output logic        ERR_OVERRUN
);

    typedef enum logic [2:0] {StIdle, StAddr, StDhi, StDlo, StChk, StHold} state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    state_e          state_q;
    logic [7:0]      addr_q;
    logic [7:0]      dhi_q;
    logic [7:0]      dlo_q;
    logic [TO_W-1:0] to_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            addr_q      <= 8'h00;
            dhi_q       <= 8'h00;
            dlo_q       <= 8'h00;
            to_cnt_q    <= '0;
            CMD_VALID   <= 1'b0;
            CMD_ADDR    <= 8'h00;
            CMD_DATA    <= 16'h0000;
            ERR_CHK     <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            ERR_OVERRUN <= 1'b0;
        end else begin
            // Error outputs are pulses; only the branches below can raise them.
            ERR_CHK     <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
            ERR_OVERRUN <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    to_cnt_q <= '0;
                    if (RXD_READY && DATA == SYNC_BYTE) begin
                        state_q <= StAddr;
                    end
                end

                StAddr, StDhi, StDlo, StChk: begin
                    if (RXD_READY) begin
                        // A byte in the timeout cycle still wins over the timeout.
                        to_cnt_q <= '0;
                        unique case (state_q)
                            StAddr: begin
                                addr_q  <= DATA;
                                state_q <= StDhi;
                            end
                            StDhi: begin
                                dhi_q   <= DATA;
                                state_q <= StDlo;
                            end
                            StDlo: begin
                                dlo_q   <= DATA;
                                state_q <= StChk;
                            end
                            default: begin
                                if (DATA == (addr_q ^ dhi_q ^ dlo_q)) begin
                                    CMD_ADDR  <= addr_q;
                                    CMD_DATA  <= {dhi_q, dlo_q};
                                    CMD_VALID <= 1'b1;
                                    state_q   <= StHold;
                                end else begin
                                    ERR_CHK <= 1'b1;
                                    state_q <= StIdle;
                                end
                            end
                        endcase
                    end else if (to_cnt_q == ToLast) begin
                        ERR_TIMEOUT <= 1'b1;
                        to_cnt_q    <= '0;
                        state_q     <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                StHold: begin
                    to_cnt_q <= '0;
                    if (CMD_READY) begin
                        // Handshake frees the slot, so a coincident byte is seen as in idle.
                        CMD_VALID <= 1'b0;
                        if (RXD_READY && DATA == SYNC_BYTE) begin
                            state_q <= StAddr;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (RXD_READY) begin
                        ERR_OVERRUN <= 1'b1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser (TIMEOUT=200). Expected commands and error
// pulses are queued when stimulus is driven and compared by a monitor on the falling edge.
module tb_uart_cmd_parser;

    localparam int unsigned Timeout = 200;
    localparam logic [2:0] EChk = 3'b001;
    localparam logic [2:0] ETo  = 3'b010;
    localparam logic [2:0] EOvr = 3'b100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  DATA = 8'h00;
    logic        RXD_READY = 1'b0;
    logic        CMD_VALID;
    logic        CMD_READY = 1'b1;
    logic [7:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        ERR_CHK;
    logic        ERR_TIMEOUT;
    logic        ERR_OVERRUN;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] exp_cmd[$];
    logic [2:0]  exp_errq[$];

    uart_cmd_parser #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT  (Timeout),
        .TO_W     (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA       (DATA),
        .RXD_READY  (RXD_READY),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_DATA   (CMD_DATA),
        .ERR_CHK    (ERR_CHK),
        .ERR_TIMEOUT(ERR_TIMEOUT),
        .ERR_OVERRUN(ERR_OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: accepted commands and error pulses are matched against the queues.
    always @(negedge CLK) begin
        logic [2:0] code;
        logic [23:0] e;
        if (!RST) begin
            if (CMD_VALID && CMD_READY) begin
                if (exp_cmd.size() == 0) begin
                    check_eq("cmd_unexpected", 32'(CMD_VALID), 32'd0);
                end else begin
                    e = exp_cmd.pop_front();
                    check_eq("cmd_addr_data", 32'({CMD_ADDR, CMD_DATA}), 32'(e));
                end
            end
            code = {ERR_OVERRUN, ERR_TIMEOUT, ERR_CHK};
            if (code != 3'b000) begin
                if (exp_errq.size() == 0) begin
                    check_eq("err_unexpected", 32'(code), 32'd0);
                end else begin
                    check_eq("err_code", 32'(code), 32'(exp_errq.pop_front()));
                end
            end
        end
    end

    // Drives one strobe; returns on the falling edge right after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        DATA      = b;
        RXD_READY = 1'b1;
        @(posedge CLK);
        #1;
        RXD_READY = 1'b0;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
    endtask

    // Five bytes with the usual spacing; checks CMD_VALID right after the last strobe.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                              input logic [7:0] c, input logic exp_valid);
        send_byte(8'hA5); idle(10);
        send_byte(a);     idle(10);
        send_byte(h);     idle(10);
        send_byte(l);     idle(10);
        send_byte(c);
        check_eq("valid_after_chk", 32'(CMD_VALID), 32'(exp_valid));
    endtask

    initial begin
        int first_to;

        // Reset state
        idle(3);
        @(negedge CLK);
        check_eq("rst_outputs", 32'({CMD_VALID, CMD_ADDR, CMD_DATA, ERR_CHK, ERR_TIMEOUT,
                                     ERR_OVERRUN}), 32'd0);
        @(posedge CLK); #1 RST = 1'b0;
        idle(5);

        // Good frame, CMD_READY high: valid for exactly one cycle
        exp_cmd.push_back({8'h0D, 16'h0301});
        send_frame(8'h0D, 8'h03, 8'h01, 8'h0F, 1'b1);
        check_eq("cmd1_addr", 32'(CMD_ADDR), 32'h0D);
        check_eq("cmd1_data", 32'(CMD_DATA), 32'h0301);
        @(negedge CLK);
        check_eq("cmd1_deassert", 32'(CMD_VALID), 32'd0);
        idle(10);

        // Bad checksum, then a good frame
        exp_errq.push_back(EChk);
        send_frame(8'h0D, 8'h03, 8'h01, 8'h0E, 1'b0);
        check_eq("errchk_pulse", 32'(ERR_CHK), 32'd1);
        @(negedge CLK);
        check_eq("errchk_one_cycle", 32'(ERR_CHK), 32'd0);
        idle(10);
        exp_cmd.push_back({8'h20, 16'h0005});
        send_frame(8'h20, 8'h00, 8'h05, 8'h25, 1'b1);
        idle(10);

        // Leading junk byte ignored
        send_byte(8'h11); idle(10);
        exp_cmd.push_back({8'h06, 16'h1234});
        send_frame(8'h06, 8'h12, 8'h34, 8'h20, 1'b1);
        idle(10);

        // Overrun while holding
        CMD_READY = 1'b0;
        exp_cmd.push_back({8'h01, 16'hAA55});
        send_frame(8'h01, 8'hAA, 8'h55, 8'hFE, 1'b1);
        idle(10);
        exp_errq.push_back(EOvr);
        send_byte(8'h77);
        check_eq("overrun_pulse", 32'(ERR_OVERRUN), 32'd1);
        check_eq("hold_valid", 32'(CMD_VALID), 32'd1);
        check_eq("hold_addr_data", 32'({CMD_ADDR, CMD_DATA}), 32'h01AA55);
        idle(10);
        @(posedge CLK); #1 CMD_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check_eq("hold_release", 32'(CMD_VALID), 32'd0);
        idle(10);

        // Handshake and SYNC byte in the same cycle: byte starts a new frame, no overrun
        CMD_READY = 1'b0;
        exp_cmd.push_back({8'h06, 16'h1234});
        send_frame(8'h06, 8'h12, 8'h34, 8'h20, 1'b1);
        idle(10);
        @(posedge CLK); #1;
        CMD_READY = 1'b1;
        DATA      = 8'hA5;
        RXD_READY = 1'b1;
        @(posedge CLK); #1 RXD_READY = 1'b0;
        idle(10);
        exp_cmd.push_back({8'h0D, 16'h0301});
        send_byte(8'h0D); idle(10);
        send_byte(8'h03); idle(10);
        send_byte(8'h01); idle(10);
        send_byte(8'h0F);
        check_eq("resync_valid", 32'(CMD_VALID), 32'd1);
        idle(10);

        // Timeout exactly TIMEOUT cycles after the last strobe
        exp_errq.push_back(ETo);
        send_byte(8'hA5); idle(10);
        send_byte(8'h0D);
        first_to = -1;
        for (int i = 1; i <= 250; i++) begin
            @(negedge CLK);
            if (ERR_TIMEOUT && first_to < 0) first_to = i;
        end
        check_eq("timeout_cycle", 32'(first_to), 32'(Timeout));
        exp_cmd.push_back({8'h0D, 16'h0301});
        send_frame(8'h0D, 8'h03, 8'h01, 8'h0F, 1'b1);
        idle(10);

        // Strobe in the last allowed cycle beats the timeout
        exp_cmd.push_back({8'h0D, 16'h0301});
        send_byte(8'hA5); idle(10);
        send_byte(8'h0D); idle(Timeout - 2);
        send_byte(8'h03); idle(10);
        send_byte(8'h01); idle(10);
        send_byte(8'h0F);
        check_eq("late_strobe_valid", 32'(CMD_VALID), 32'd1);
        idle(10);

        // Reset mid-frame discards it silently
        send_byte(8'hA5); idle(10);
        send_byte(8'h0D); idle(10);
        send_byte(8'h03); idle(3);
        @(posedge CLK); #1 RST = 1'b1;
        idle(2);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_eq("midrst_outputs", 32'({CMD_VALID, ERR_CHK, ERR_TIMEOUT, ERR_OVERRUN}), 32'd0);
        idle(10);
        exp_cmd.push_back({8'h0D, 16'h0301});
        send_frame(8'h0D, 8'h03, 8'h01, 8'h0F, 1'b1);
        idle(20);

        check_eq("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
        check_eq("err_queue_drained", 32'(exp_errq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
